cube_bus_monitor: RTL
=====================

# cube_bus_monitor

Receive-side model of the LED-cube driver bus: samples the 8 layer-select, 8 latch-clock and 8 data lines as the cube PCB sees them and reconstructs the displayed 8×8×8 voxel image. It sits on the FPGA in loopback from the GPIO header or on the bus in simulation. It models the eight 74HC574-style row latches and captures a layer's image only once that layer has been held stably. It flags ghosting when more than one layer is driven at once, and exposes the captured image through a registered read port.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops on every bus input (minimum 2)
- MIN_ON_CYCLES, 16, consecutive stable cycles a single layer must be lit before its image is captured (minimum 2)

- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- layers_in  in  8  layer enables from bus, bit i = layer i, active high, asynchronous
- latches_in  in  8  latch clocks from bus, bit i = row latch i, asynchronous
- data_in  in  8  shared data bus, asynchronous
- rd_layer  in  3  read-port layer index
- rd_row  in  3  read-port row (latch) index
- rd_data  out  8  captured image[rd_layer][rd_row], registered
- layer_valid  out  8  bit i set once layer i has been captured in the current frame
- frame_count  out  16  completed frames, wraps at 16'hFFFF→0
- ghost_err  out  1  sticky: more than one layer was ever active
- err_count  out  8  number of ghost events, saturates at 8'hFF

## Operation
- All 24 inputs pass through SYNC_STAGES flops, giving the synced vectors lay, lat and dat. A further register holds lat_d (previous lat).
- Latch model: for each i with lat[i] & ~lat_d[i], latch_q[i] <= dat. Simultaneous edges on several latches all load the same dat. A latch with no edge holds its value.
- Layer state machine, evaluated on lay each cycle:
  - IDLE: lay == 0 or not one-hot. If lay is one-hot, go to COUNT with stable_cnt = 1.
  - COUNT: on the same one-hot lay with no latch edge, stable_cnt++. If any latch edge occurs, stable_cnt = 1. If lay changes to another one-hot value, stable_cnt = 1 and the state stays COUNT on the new layer. If lay becomes zero or multi-hot, go to IDLE. When stable_cnt == MIN_ON_CYCLES, capture and go to CAPTURED.
  - CAPTURED: hold while lay is unchanged. Latch edges are ignored, with no re-capture. When lay changes, apply the IDLE rules to the new value in that same cycle.
- Capture of layer L: image[L][r] <= latch_q[r] for r = 0..7.
  - Let nv = layer_valid | (1<<L).
  - If nv == 8'hFF: layer_valid <= 0 and frame_count++.
  - Otherwise: layer_valid <= nv.
  - Recapturing an already-valid layer overwrites the image and leaves layer_valid unchanged.
- Ghost detection: popcount(lay) > 1 while popcount(lay_prev) ≤ 1 sets ghost_err and increments err_count (saturating). A sustained multi-hot condition counts once.
- Read port: rd_data <= image[rd_layer][rd_row] every cycle.
- Reset, on any cycle including mid-count or mid-capture, zeroes all of the following: image, latch_q, lat_d, synchronizers, layer_valid, frame_count, ghost_err, err_count, rd_data, stable_cnt; the state goes to IDLE. All outputs are 0 on the cycle after reset.

## Timing
- Pin edge to synced value: SYNC_STAGES cycles. A latch_q load occurs SYNC_STAGES+1 cycles after the latch pin rises.
- Image and layer_valid update on the clock edge ending the MIN_ON_CYCLES-th stable cycle. They are visible one cycle later.
- rd_data latency: 1 cycle from rd_layer/rd_row.
- frame_count increments on the same edge as the 8th distinct layer capture.
- Ghost flags update one cycle after the multi-hot lay is seen.
- Pulses narrower than one CLOCK_50 period may be missed. The bus must hold each level for at least 2 cycles.

## Test plan
- Load latches: data_in = 8'hA5 with a pulse on latch 0, then 8'h3C on latch 7; hold layers_in = 8'h04 for 20 cycles. Required: image[2][0] = A5, image[2][7] = 3C, other rows 00, layer_valid = 8'h04, captured exactly once.
- Hold layer 3 for MIN_ON_CYCLES-1 cycles, then switch to 0. Required: no capture, layer_valid = 0.
- Pulse latch 1 with data_in = 8'hFF after 10 cycles of layer 5 being lit. Required: count restarts and capture occurs at cycle 10+16; image[5][1] = FF.
- Scan layers 0..7, 20 cycles each, twice. Required: frame_count = 2, layer_valid = 0, and the final image matches the second pass.
- Drive layers_in = 8'h81 for 30 cycles, then 0, then 8'h03. Required: ghost_err = 1, err_count = 2, no captures.
- Assert reset for 1 cycle mid-COUNT after a frame has completed. Required: all outputs are 0 and rd_data = 0 for every address.

Source files
------------

// File: rtl/cube_bus_monitor.sv
// rtl/cube_bus_monitor.sv - receive-side LED-cube bus monitor with latch model and image capture
module cube_bus_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_ON_CYCLES = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  layers_in,
    input  logic [7:0]  latches_in,
    input  logic [7:0]  data_in,
    input  logic [2:0]  rd_layer,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_data,
    output logic [7:0]  layer_valid,
    output logic [15:0] frame_count,
    output logic        ghost_err,
    output logic [7:0]  err_count
);

    localparam int CW = $clog2(MIN_ON_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COUNT, CAPTURED} state_t;

    function automatic logic is_multi(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'd0) && !is_multi(v);
    endfunction

    function automatic logic [2:0] oh_index(input logic [7:0] v);
        oh_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) oh_index = 3'(i);
        end
    endfunction

    logic [23:0]   sync_q [SYNC_STAGES];
    logic [7:0]    lay, lat, dat;
    logic [7:0]    lat_d_q;
    logic [7:0]    lay_prev_q;
    logic [7:0]    latch_q [8];
    logic [7:0]    image_q [8][8];
    logic [7:0]    cur_q, cur_d;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d, cnt_inc;
    state_t        state_q, state_d;
    logic          capture;
    logic [7:0]    lat_edge;
    logic [7:0]    valid_q, nv;
    logic [15:0]   frame_q;
    logic          ghost_q;
    logic [7:0]    err_q;
    logic [7:0]    rd_data_q;
    logic          ghost_evt;

    assign lay      = sync_q[SYNC_STAGES-1][23:16];
    assign lat      = sync_q[SYNC_STAGES-1][15:8];
    assign dat      = sync_q[SYNC_STAGES-1][7:0];
    assign lat_edge = lat & ~lat_d_q;
    assign cnt_inc  = stable_cnt_q + CW'(1);
    assign nv       = valid_q | (8'd1 << oh_index(cur_q));
    // A sustained multi-hot bus only counts on its leading cycle.
    assign ghost_evt = is_multi(lay) && !is_multi(lay_prev_q);

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        cur_d        = cur_q;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_one_hot(lay)) begin
                    state_d      = COUNT;
                    stable_cnt_d = CW'(1);
                    cur_d        = lay;
                end
            end
            COUNT: begin
                if (lay == cur_q) begin
                    if (|lat_edge) begin
                        stable_cnt_d = CW'(1);
                    end else begin
                        stable_cnt_d = cnt_inc;
                        if (cnt_inc == CW'(MIN_ON_CYCLES)) begin
                            capture = 1'b1;
                            state_d = CAPTURED;
                        end
                    end
                end else if (is_one_hot(lay)) begin
                    stable_cnt_d = CW'(1);
                    cur_d        = lay;
                end else begin
                    state_d      = IDLE;
                    stable_cnt_d = '0;
                end
            end
            CAPTURED: begin
                if (lay != cur_q) begin
                    if (is_one_hot(lay)) begin
                        state_d      = COUNT;
                        stable_cnt_d = CW'(1);
                        cur_d        = lay;
                    end else begin
                        state_d      = IDLE;
                        stable_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                stable_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < 8; i++) begin
                latch_q[i] <= '0;
                for (int r = 0; r < 8; r++) image_q[i][r] <= '0;
            end
            lat_d_q      <= '0;
            lay_prev_q   <= '0;
            cur_q        <= '0;
            stable_cnt_q <= '0;
            state_q      <= IDLE;
            valid_q      <= '0;
            frame_q      <= '0;
            ghost_q      <= 1'b0;
            err_q        <= '0;
            rd_data_q    <= '0;
        end else begin
            sync_q[0] <= {layers_in, latches_in, data_in};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            lat_d_q    <= lat;
            lay_prev_q <= lay;
            for (int i = 0; i < 8; i++) begin
                if (lat_edge[i]) latch_q[i] <= dat;
            end
            cur_q        <= cur_d;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            if (capture) begin
                for (int r = 0; r < 8; r++) image_q[oh_index(cur_q)][r] <= latch_q[r];
                if (nv == 8'hFF) begin
                    valid_q <= '0;
                    frame_q <= frame_q + 16'd1;
                end else begin
                    valid_q <= nv;
                end
            end
            if (ghost_evt) begin
                ghost_q <= 1'b1;
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            end
            rd_data_q <= image_q[rd_layer][rd_row];
        end
    end

    assign rd_data     = rd_data_q;
    assign layer_valid = valid_q;
    assign frame_count = frame_q;
    assign ghost_err   = ghost_q;
    assign err_count   = err_q;

endmodule
